// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet receiver slice.
package pkt_pkg;

  localparam int PKT_W     = 13;
  localparam int PAYLOAD_W = 8;

  typedef struct packed {
    logic                 eop;
    logic [PAYLOAD_W-1:0] payload;
    logic [1:0]           ptype;
    logic [1:0]           dest;
  } packet_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE,
    DROP
  } rx_state_e;

  // Increment that sticks at the top of the 8-bit range.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Small synchronous flit FIFO; storage is a flop array, head entry presented
// directly so a flit written in one cycle is poppable the next.
module pkt_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packet_receiver.sv
// Destination-side frame reassembler: buffers flits, filters by address,
// and reports length/type/checksum for each accepted frame.
//
// state   | meaning
// IDLE    | waiting for the first flit of a frame
// COLLECT | accumulating flits of an addressed frame
// DONE    | frame summary held until consumer accepts it
// DROP    | discarding flits up to eop (misaddressed or truncated tail)
module packet_receiver
  import pkt_pkg::*;
#(
  parameter logic [1:0] NODE_ADDR  = 2'd0,
  parameter int         FIFO_DEPTH = 4,
  parameter int         MAX_LEN    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           src_valid,
  input  logic [PKT_W-1:0]               packet,
  output logic                           src_ready,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic [1:0]                     frame_type,
  output logic [$clog2(MAX_LEN+1)-1:0]   frame_len,
  output logic [PAYLOAD_W-1:0]           frame_sum,
  output logic                           frame_err,
  output logic                           complete,
  output logic [7:0]                     drop_count
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  rx_state_e            state_q, state_d;
  logic [1:0]           type_q, type_d;
  logic [LEN_W-1:0]     len_q, len_d, len_inc;
  logic [PAYLOAD_W-1:0] sum_q, sum_d;
  logic                 err_q, err_d;
  logic                 trunc_q, trunc_d;
  logic                 mis_q, mis_d;
  logic [7:0]           drop_q, drop_d;

  logic [PKT_W-1:0]     fifo_rd;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  packet_t              flit;

  // Ready is held low while reset is applied so nothing is taken mid-reset.
  assign src_ready = !fifo_full && !rst;
  assign fifo_pop  = !fifo_empty && (state_q != DONE);
  assign flit      = fifo_rd;
  assign len_inc   = len_q + LEN_W'(1);

  pkt_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (src_valid && src_ready),
    .wr_data (packet),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign frame_valid = (state_q == DONE);
  assign complete    = frame_valid && frame_ready;
  assign frame_type  = type_q;
  assign frame_len   = len_q;
  assign frame_sum   = sum_q;
  assign frame_err   = err_q;
  assign drop_count  = drop_q;

  // State and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      type_q  <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      trunc_q <= 1'b0;
      mis_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      trunc_q <= trunc_d;
      mis_q   <= mis_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and accumulator update; one flit consumed per popping cycle.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    len_d   = len_q;
    sum_d   = sum_q;
    err_d   = err_q;
    trunc_d = trunc_q;
    mis_d   = mis_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (flit.dest == NODE_ADDR) begin
            type_d  = flit.ptype;
            len_d   = LEN_W'(1);
            sum_d   = flit.payload;
            err_d   = 1'b0;
            state_d = flit.eop ? DONE : COLLECT;
          end else if (flit.eop) begin
            drop_d = sat_inc8(drop_q);
          end else begin
            mis_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      COLLECT: begin
        if (!fifo_empty) begin
          len_d = len_inc;
          sum_d = sum_q + flit.payload;
          if (flit.eop) begin
            state_d = DONE;
          end else if (len_inc == LEN_W'(MAX_LEN)) begin
            err_d   = 1'b1;
            trunc_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (frame_ready) begin
          err_d   = 1'b0;
          trunc_d = 1'b0;
          mis_d   = 1'b0;
          state_d = trunc_q ? DROP : IDLE;
        end
      end
      DROP: begin
        if (!fifo_empty && flit.eop) begin
          // Truncated tails are not misaddressed frames and are not counted.
          if (mis_q) drop_d = sat_inc8(drop_q);
          mis_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_packet_receiver.sv
module tb_packet_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_valid;
  logic [12:0] packet;
  logic        src_ready;
  logic        frame_valid;
  logic        frame_ready;
  logic [1:0]  frame_type;
  logic [4:0]  frame_len;
  logic [7:0]  frame_sum;
  logic        frame_err;
  logic        complete;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] t;
    logic [4:0] l;
    logic [7:0] s;
    logic       e;
    logic       c;
  } frame_t;

  frame_t fq[$];

  packet_receiver #(
    .NODE_ADDR  (2'd0),
    .FIFO_DEPTH (4),
    .MAX_LEN    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .packet      (packet),
    .src_ready   (src_ready),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_type  (frame_type),
    .frame_len   (frame_len),
    .frame_sum   (frame_sum),
    .frame_err   (frame_err),
    .complete    (complete),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Record every accepted frame, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0 && frame_valid === 1'b1 && frame_ready === 1'b1)
      fq.push_back('{t: frame_type, l: frame_len, s: frame_sum, e: frame_err, c: complete});
  end

  function automatic logic [12:0] mk(input logic eop, input logic [7:0] pl,
                                     input logic [1:0] ty, input logic [1:0] de);
    return {eop, pl, ty, de};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [12:0] f);
    logic ok;
    ok = 1'b0;
    src_valid = 1'b1;
    packet = f;
    for (int i = 0; i < 200; i++) begin
      if (src_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    src_valid = 1'b0;
    check("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 300 && fq.size() < n; i++) begin
      @(posedge clk); #1;
    end
    check("frame_count", fq.size(), n);
  endtask

  initial begin
    rst = 1'b1;
    src_valid = 1'b0;
    packet = '0;
    frame_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_src_ready", {31'd0, src_ready}, 32'd0);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_complete", {31'd0, complete}, 32'd0);
    check("rst_len", {27'd0, frame_len}, 32'd0);
    check("rst_sum", {24'd0, frame_sum}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, src_ready}, 32'd1);

    // Single-flit frame: valid exactly two cycles after push
    src_valid = 1'b1;
    packet = 13'h1050;
    frame_ready = 1'b1;
    @(posedge clk); #1;
    src_valid = 1'b0;
    check("t1_valid_c1", {31'd0, frame_valid}, 32'd0);
    @(posedge clk); #1;
    check("t1_valid_c2", {31'd0, frame_valid}, 32'd1);
    check("t1_complete", {31'd0, complete}, 32'd1);
    check("t1_len", {27'd0, frame_len}, 32'd1);
    check("t1_sum", {24'd0, frame_sum}, 32'h05);
    check("t1_type", {30'd0, frame_type}, 32'd0);
    @(posedge clk); #1;
    check("t1_valid_c3", {31'd0, frame_valid}, 32'd0);
    fq.delete();

    // Three flits, checksum wraps: 0x80+0x90+0x10 = 0x120 -> 0x20
    send(mk(1'b0, 8'h80, 2'd2, 2'd0));
    send(mk(1'b0, 8'h90, 2'd1, 2'd3));
    send(mk(1'b1, 8'h10, 2'd0, 2'd1));
    wait_frames(1);
    check("t2_len", {27'd0, fq[0].l}, 32'd3);
    check("t2_sum", {24'd0, fq[0].s}, 32'h20);
    check("t2_type", {30'd0, fq[0].t}, 32'd2);
    check("t2_err", {31'd0, fq[0].e}, 32'd0);
    fq.delete();

    // Misaddressed two-flit frame, then addressed one
    send(mk(1'b0, 8'hAA, 2'd1, 2'd3));
    send(mk(1'b1, 8'hBB, 2'd1, 2'd3));
    send(mk(1'b1, 8'h33, 2'd1, 2'd0));
    wait_frames(1);
    repeat (3) @(posedge clk);
    #1;
    check("t3_nframes", fq.size(), 1);
    check("t3_drop", {24'd0, drop_count}, 32'd1);
    check("t3_len", {27'd0, fq[0].l}, 32'd1);
    check("t3_sum", {24'd0, fq[0].s}, 32'h33);
    check("t3_type", {30'd0, fq[0].t}, 32'd1);
    fq.delete();

    // Back-pressure: frame held, FIFO fills after 4 more flits
    frame_ready = 1'b0;
    send(mk(1'b1, 8'h11, 2'd3, 2'd0));
    for (int i = 0; i < 50 && frame_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("t4_held_valid", {31'd0, frame_valid}, 32'd1);
    send(mk(1'b0, 8'h01, 2'd1, 2'd0));
    send(mk(1'b0, 8'h02, 2'd0, 2'd0));
    send(mk(1'b0, 8'h03, 2'd0, 2'd0));
    check("t4_ready_3", {31'd0, src_ready}, 32'd1);
    send(mk(1'b1, 8'h04, 2'd0, 2'd0));
    check("t4_ready_full", {31'd0, src_ready}, 32'd0);
    check("t4_still_valid", {31'd0, frame_valid}, 32'd1);
    check("t4_no_frame_yet", fq.size(), 0);
    frame_ready = 1'b1;
    #1;
    check("t4_complete", {31'd0, complete}, 32'd1);
    wait_frames(2);
    check("t4_a_sum", {24'd0, fq[0].s}, 32'h11);
    check("t4_a_type", {30'd0, fq[0].t}, 32'd3);
    check("t4_a_c", {31'd0, fq[0].c}, 32'd1);
    check("t4_b_len", {27'd0, fq[1].l}, 32'd4);
    check("t4_b_sum", {24'd0, fq[1].s}, 32'h0A);
    check("t4_b_type", {30'd0, fq[1].t}, 32'd1);
    fq.delete();

    // Truncation: 20 flits, payloads 1..20; first 16 sum to 0x88
    for (int i = 1; i <= 20; i++)
      send(mk(i == 20, 8'(i), (i == 1) ? 2'd2 : 2'd1, 2'd0));
    send(mk(1'b1, 8'h44, 2'd0, 2'd0));
    wait_frames(2);
    repeat (3) @(posedge clk);
    #1;
    check("t5_nframes", fq.size(), 2);
    check("t5_len", {27'd0, fq[0].l}, 32'd16);
    check("t5_err", {31'd0, fq[0].e}, 32'd1);
    check("t5_sum", {24'd0, fq[0].s}, 32'h88);
    check("t5_type", {30'd0, fq[0].t}, 32'd2);
    check("t5_drop", {24'd0, drop_count}, 32'd1);
    check("t5_next_len", {27'd0, fq[1].l}, 32'd1);
    check("t5_next_err", {31'd0, fq[1].e}, 32'd0);
    check("t5_next_sum", {24'd0, fq[1].s}, 32'h44);
    fq.delete();

    // Reset mid-frame
    send(mk(1'b0, 8'h21, 2'd1, 2'd0));
    send(mk(1'b0, 8'h22, 2'd1, 2'd0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t6_valid", {31'd0, frame_valid}, 32'd0);
    check("t6_len", {27'd0, frame_len}, 32'd0);
    check("t6_sum", {24'd0, frame_sum}, 32'd0);
    check("t6_drop", {24'd0, drop_count}, 32'd0);
    check("t6_ready", {31'd0, src_ready}, 32'd1);
    fq.delete();
    send(mk(1'b1, 8'h07, 2'd1, 2'd0));
    wait_frames(1);
    check("t6_new_len", {27'd0, fq[0].l}, 32'd1);
    check("t6_new_sum", {24'd0, fq[0].s}, 32'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
